// File: rtl/dual_rail_pkg.sv
// Shared dual-rail code words and rail-pair validity helper.
// A rail pair is written {p, n}; only 01 and 10 carry data.
package dual_rail_pkg;

    typedef enum logic [1:0] {
        DR_NULL    = 2'b00,
        DR_ZERO    = 2'b01,
        DR_ONE     = 2'b10,
        DR_ILLEGAL = 2'b11
    } dr_code_t;

    function automatic logic dr_valid(input logic p, input logic n);
        return p ^ n;
    endfunction

endpackage

// File: rtl/dual_rail_lane.sv
// One lane: rail-consistency check plus truth-table lookup, purely combinational.
// A faulty lane returns the null code word and raises err.
module dual_rail_lane
    import dual_rail_pkg::*;
#(
    parameter int                   N_IN  = 4,
    parameter logic [(1<<N_IN)-1:0] TRUTH = 16'h8E3C
) (
    input  logic [N_IN-1:0] in_p,
    input  logic [N_IN-1:0] in_n,
    output logic            res_p,
    output logic            res_n,
    output logic            err
);

    logic     good;
    dr_code_t code;

    always_comb begin
        good = 1'b1;
        for (int unsigned i = 0; i < N_IN; i++) begin
            good = good & dr_valid(in_p[i], in_n[i]);
        end
        if (!good)
            code = DR_NULL;
        else if (TRUTH[in_p])
            code = DR_ONE;
        else
            code = DR_ZERO;
        {res_p, res_n} = code;
        err            = !good;
    end

endmodule

// File: rtl/dual_rail_lut_eval.sv
// Registered multi-lane dual-rail LUT evaluator with valid/ready handshake
// and a saturating count of words that contained any faulty lane.
module dual_rail_lut_eval
    import dual_rail_pkg::*;
#(
    parameter int N_IN     = 4,
    parameter int CHANNELS = 2,
    parameter     TRUTH    = 16'h8E3C,
    parameter int CNT_W    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CHANNELS*N_IN-1:0] in_p,
    input  logic [CHANNELS*N_IN-1:0] in_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [CHANNELS-1:0]      out_p,
    output logic [CHANNELS-1:0]      out_n,
    output logic [CHANNELS-1:0]      out_err,
    output logic                     out_valid,
    input  logic                     out_ready,
    input  logic                     err_clr,
    output logic [CNT_W-1:0]         err_count
);

    if (N_IN < 1 || N_IN > 6 || $bits(TRUTH) != (1 << N_IN)) begin : g_bad_cfg
        $error("dual_rail_lut_eval: N_IN must be 1..6 and TRUTH must be 2**N_IN bits wide");
    end

    logic [CHANNELS-1:0] lane_p;
    logic [CHANNELS-1:0] lane_n;
    logic [CHANNELS-1:0] lane_err;
    logic                accept;
    logic [CNT_W-1:0]    cnt_base;
    logic [CNT_W-1:0]    cnt_next;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        dual_rail_lane #(
            .N_IN  (N_IN),
            .TRUTH (TRUTH)
        ) u_lane (
            .in_p  (in_p[c*N_IN +: N_IN]),
            .in_n  (in_n[c*N_IN +: N_IN]),
            .res_p (lane_p[c]),
            .res_n (lane_n[c]),
            .err   (lane_err[c])
        );
    end

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Clear is applied before the increment so clear plus a faulty word lands on 1.
    always_comb begin
        cnt_base = err_clr ? '0 : err_count;
        cnt_next = cnt_base;
        if (accept && (|lane_err) && (cnt_base != '1))
            cnt_next = cnt_base + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_p     <= '0;
            out_n     <= '0;
            out_err   <= '0;
            out_valid <= 1'b0;
            err_count <= '0;
        end else begin
            if (accept) begin
                out_p   <= lane_p;
                out_n   <= lane_n;
                out_err <= lane_err;
            end
            out_valid <= accept || (out_valid && !out_ready);
            err_count <= cnt_next;
        end
    end

endmodule

// File: tb/tb_dual_rail_lut_eval.sv
// Directed bench for dual_rail_lut_eval (2 lanes x 4 inputs, 2-bit counter)
// with a queue scoreboard fed at drive time and drained at result time.
module tb_dual_rail_lut_eval;

    localparam int CH = 2;
    localparam int NI = 4;
    localparam int CW = 2;

    typedef struct packed {
        logic [CH-1:0] p;
        logic [CH-1:0] n;
        logic [CH-1:0] err;
        logic [CW-1:0] cnt;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [CH*NI-1:0] in_p;
    logic [CH*NI-1:0] in_n;
    logic             in_valid;
    logic             in_ready;
    logic [CH-1:0]    out_p;
    logic [CH-1:0]    out_n;
    logic [CH-1:0]    out_err;
    logic             out_valid;
    logic             out_ready;
    logic             err_clr;
    logic [CW-1:0]    err_count;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];
    exp_t last;
    int   mcnt;

    dual_rail_lut_eval #(
        .N_IN     (NI),
        .CHANNELS (CH),
        .TRUTH    (16'h8E3C),
        .CNT_W    (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_p      (in_p),
        .in_n      (in_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_p     (out_p),
        .out_n     (out_n),
        .out_err   (out_err),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_clr   (err_clr),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Independent reference: lane good iff every rail pair differs.
    function automatic exp_t model(input logic [CH*NI-1:0] p, input logic [CH*NI-1:0] n);
        exp_t        e;
        logic [15:0] tt;
        logic [3:0]  idx;
        tt = 16'h8E3C;
        e  = '0;
        for (int c = 0; c < CH; c++) begin
            idx = p[c*NI +: NI];
            if ((p[c*NI +: NI] ^ n[c*NI +: NI]) == 4'hF) begin
                e.p[c] = tt[idx];
                e.n[c] = ~tt[idx];
            end else begin
                e.err[c] = 1'b1;
            end
        end
        return e;
    endfunction

    task automatic push_word(input logic [CH*NI-1:0] p, input logic [CH*NI-1:0] n, input logic clr);
        exp_t e;
        e = model(p, n);
        if (clr) mcnt = 0;
        if ((|e.err) && mcnt != 3) mcnt++;
        e.cnt = mcnt[CW-1:0];
        sb.push_back(e);
    endtask

    task automatic check_result(input string tag);
        exp_t e;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        assert (sb.size() != 0) else begin
            n_fail++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_p"},     32'(out_p),     32'(e.p));
            chk({tag, "_n"},     32'(out_n),     32'(e.n));
            chk({tag, "_err"},   32'(out_err),   32'(e.err));
            chk({tag, "_cnt"},   32'(err_count), 32'(e.cnt));
            last = e;
        end
    endtask

    task automatic send(input string tag, input logic [CH*NI-1:0] p, input logic [CH*NI-1:0] n,
                        input logic clr);
        in_p = p; in_n = n; in_valid = 1'b1; out_ready = 1'b1; err_clr = clr;
        push_word(p, n, clr);
        check_result(tag);
    endtask

    task automatic chk_held(input string tag);
        chk({tag, "_rdy"},   32'(in_ready),  32'd0);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_p"},     32'(out_p),     32'(last.p));
        chk({tag, "_n"},     32'(out_n),     32'(last.n));
        chk({tag, "_err"},   32'(out_err),   32'(last.err));
    endtask

    initial begin
        rst = 1'b1; in_p = '0; in_n = '0; in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
        mcnt = 0;
        last = '0;
        @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_p",     32'(out_p),     32'd0);
        chk("rst_n",     32'(out_n),     32'd0);
        chk("rst_err",   32'(out_err),   32'd0);
        chk("rst_cnt",   32'(err_count), 32'd0);
        chk("rst_rdy",   32'(in_ready),  32'd1);
        rst = 1'b0;

        // Basic evaluation, including one faulty lane.
        send("s1", {4'hF, 4'h2}, {4'h0, 4'hD}, 1'b0);
        chk("s1_p_lit", 32'(out_p), 32'h3);
        send("s2", {4'h4, 4'h6}, {4'hB, 4'h9}, 1'b0);
        chk("s2_p_lit", 32'(out_p), 32'h2);
        send("s3", {4'h3, 4'h0}, {4'h3, 4'hF}, 1'b0);
        chk("s3_err_lit", 32'(out_err), 32'h2);

        // Backpressure: word waits while out_ready is low, loads when it rises.
        in_p = {4'h9, 4'h1}; in_n = {4'h6, 4'hE}; in_valid = 1'b1; out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("s4_hold", 32'(in_ready), 32'd0);
            chk_held("s4_hold");
            @(posedge clk);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        chk("s4_rdy_up", 32'(in_ready), 32'd1);
        push_word(in_p, in_n, 1'b0);
        check_result("s4_load");

        // Counter saturation, then clear together with a faulty word.
        for (int k = 0; k < 4; k++) send("s5_bad", 8'hFF, 8'hFF, 1'b0);
        chk("s5_sat", 32'(err_count), 32'd3);
        send("s5_clr_bad", {4'h0, 4'h5}, {4'h0, 4'hA}, 1'b1);

        // Clear alone with release: count drops to 0, data outputs retained.
        in_valid = 1'b0; out_ready = 1'b1; err_clr = 1'b1;
        mcnt = 0;
        @(posedge clk);
        @(negedge clk);
        err_clr = 1'b0;
        chk("rel_valid", 32'(out_valid), 32'd0);
        chk("rel_cnt",   32'(err_count), 32'd0);
        chk("rel_p",     32'(out_p),     32'(last.p));
        chk("rel_n",     32'(out_n),     32'(last.n));
        chk("rel_err",   32'(out_err),   32'(last.err));

        // Reset during a hold discards the pending result without a clock edge.
        send("s6_pre", {4'h3, 4'h2}, {4'hC, 4'hC}, 1'b0);
        in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_held("s6_hold");
        #2 rst = 1'b1;
        #1;
        chk("s6_rst_valid", 32'(out_valid), 32'd0);
        chk("s6_rst_p",     32'(out_p),     32'd0);
        chk("s6_rst_n",     32'(out_n),     32'd0);
        chk("s6_rst_err",   32'(out_err),   32'd0);
        chk("s6_rst_cnt",   32'(err_count), 32'd0);
        chk("s6_rst_rdy",   32'(in_ready),  32'd1);
        sb.delete();
        mcnt = 0;
        @(negedge clk);
        rst = 1'b0;
        send("s6_after", {4'hF, 4'h2}, {4'h0, 4'hD}, 1'b0);
        chk("s6_after_lit", 32'(out_p), 32'h3);

        in_valid = 1'b0;
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dual_rail_lut_eval.md
Name: dual_rail_lut_eval

Overview:
- Parametrised, registered successor to the team's dual-rail switch-level function cells.
- CHANNELS lanes, each taking an N_IN-bit dual-rail input word (true rail plus complement rail), checked for rail consistency.
- Each valid lane is evaluated against a truth-table parameter and returned as a dual-rail result.
- Valid/ready handshake on both sides; saturating counter of faulty transfers for system-level monitoring.

Parameters:
- N_IN, 4, inputs per lane. Range 1..6.
- CHANNELS, 2, number of independent lanes.
- TRUTH, 16'h8E3C, truth table of width 2**N_IN. Bit k is the function value for input index k.
- CNT_W, 8, width of the error counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- in_p  in  CHANNELS*N_IN  true rails; lane c occupies bits [c*N_IN +: N_IN]
- in_n  in  CHANNELS*N_IN  complement rails, same layout as in_p
- in_valid  in  1  input word present
- in_ready  out  1  block can accept a word this cycle
- out_p  out  CHANNELS  true rail of each lane result
- out_n  out  CHANNELS  complement rail of each lane result
- out_err  out  CHANNELS  per-lane rail-violation flag
- out_valid  out  1  result registers hold an undelivered result
- out_ready  in  1  downstream accepts the result
- err_clr  in  1  synchronous clear of err_count
- err_count  out  CNT_W  saturating count of faulty transfers

Behaviour:
- Reset (async, immediate on rst high): out_p=0, out_n=0, out_err=0, out_valid=0, err_count=0. in_ready reads 1 while out_valid=0.
- in_ready = !out_valid || out_ready. This is combinational, with no bubble under continuous flow.
- Accept happens when in_valid && in_ready on a rising edge. Latency is 1 cycle: the result is visible on the next cycle with out_valid=1.
- Lane check: lane c is good if in_p[b] ^ in_n[b] = 1 for every bit b of the lane.
- Good lane:
  - idx = in_p lane bits, with bit i of idx = in_p[c*N_IN+i].
  - out_p[c] = TRUTH[idx]; out_n[c] = ~TRUTH[idx]; out_err[c] = 0.
- Bad lane (any pair 00 or 11):
  - out_p[c] = 0, out_n[c] = 0 (null code word); out_err[c] = 1.
  - Other lanes of the same word are evaluated normally.
- Hold: while out_valid && !out_ready, all out_* are stable and no input is accepted.
- Release: out_ready && out_valid && !in_valid clears out_valid on the next edge. Data outputs keep their last values.
- Simultaneous release and accept: new result loads, out_valid stays 1.
- err_count:
  - Increments by 1 per accepted word with any out_err bit set.
  - Saturates at 2**CNT_W-1 and never wraps.
- err_clr and faulty accept in the same cycle: clear applies first, then the count, so err_count = 1. err_clr alone gives 0.
- Inputs are sampled only on an accept. in_p/in_n may change freely otherwise.
- Reset mid-transfer: the pending result is discarded and out_valid drops immediately. No partial update.
- N_IN outside 1..6, or a TRUTH width mismatch, is an elaboration error.

Decomposition:
- Shared package dual_rail_pkg:
  - Rail code constants: DR_NULL=2'b00, DR_ZERO=2'b01 (n=1, p=0), DR_ONE=2'b10, DR_ILLEGAL=2'b11.
  - Function dr_valid(p,n).
- One sub-module: dual_rail_lane, a combinational check plus LUT for one lane.
  - Instantiated CHANNELS times with a generate loop.
  - Handshake, result registers and counter stay in the top module.

Test Plan (CHANNELS=2, N_IN=4, TRUTH=16'h8E3C, CNT_W=2):
1. Reset released, then lane0 p=4'h2/n=4'hD and lane1 p=4'hF/n=4'h0 with out_ready=1. Next cycle: out_valid=1, out_p=2'b11, out_n=2'b00, out_err=0, err_count=0.
2. Lane0 p=4'h6/n=4'h9 and lane1 p=4'h4/n=4'hB. Next cycle: out_p=2'b10, out_n=2'b01.
3. Lane1 p=4'h3/n=4'h3 (bad), lane0 p=4'h0/n=4'hF. Next cycle: out_err=2'b10, out_p=2'b00, out_n=2'b01, err_count=1.
4. Hold out_ready=0 for 3 cycles with in_valid=1:
   - in_ready=0 and outputs stable throughout.
   - Raising out_ready loads the next word in the same edge.
   - out_valid never drops.
5. Four consecutive bad words:
   - err_count reaches 3 and stays at 3.
   - Then err_clr together with a bad word gives err_count=1.
6. Assert rst mid-hold with out_valid=1:
   - Outputs are 0 immediately, with no clock edge needed.
   - in_ready=1; the first accept after release behaves as in scenario 1.
